// File: rtl/ctrl_pkg.sv
// Shared types and constants for the instruction controller.
// Optional debug state port is enabled by defining CTRL_STATE_OUT_EN.
package ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned RF_AW   = 4;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned STATE_W = 4;

    // Encodings are fixed so the debug display can show them directly.
    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_WAIT   = 4'd2,
        S_DECODE = 4'd3,
        S_NOOP   = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_STORE  = 4'd7,
        S_ADD    = 4'd8,
        S_SUB    = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    localparam logic [OP_W-1:0] OP_NOOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_STORE = 4'h1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OP_W-1:0] OP_HALT  = 4'h5;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/instr_controller_if.sv
// Controller-to-datapath bus: instruction ROM, data memory and register-file controls.
interface instr_controller_if
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = 7,
    parameter int unsigned DADDR_W = 8
);
    logic [INSTR_W-1:0] InstrData;
    logic [PC_W-1:0]    InstrAddr;
    logic [DADDR_W-1:0] D_Addr;
    logic               D_Wr;
    logic               RF_s;
    logic               RF_W_en;
    logic [RF_AW-1:0]   RF_W_addr;
    logic [RF_AW-1:0]   RF_Ra_addr;
    logic [RF_AW-1:0]   RF_Rb_addr;
    logic [ALU_W-1:0]   ALU_s;
    logic               Halted;

    modport master (
        input  InstrData,
        output InstrAddr, D_Addr, D_Wr, RF_s, RF_W_en,
        output RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s, Halted
    );

    modport slave (
        output InstrData,
        input  InstrAddr, D_Addr, D_Wr, RF_s, RF_W_en,
        input  RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s, Halted
    );
endinterface

// File: rtl/pc_ir_reg.sv
// Program counter and instruction register; both advance together on a load strobe.
module pc_ir_reg #(
    parameter int unsigned PC_W = 7,
    parameter int unsigned IR_W = 16
) (
    input  logic            Clk,
    input  logic            ResetN,
    input  logic            load,
    input  logic [IR_W-1:0] instr_data,
    output logic [PC_W-1:0] pc,
    output logic [IR_W-1:0] ir
);

    // PC wraps naturally at 2**PC_W.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            pc <= '0;
            ir <= '0;
        end else if (load) begin
            ir <= instr_data;
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_controller.sv
// Multi-cycle fetch/decode/execute controller driving the register-file datapath.
// Define CTRL_STATE_OUT_EN to expose the state encoding on CurState.
module instr_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = 7,
    parameter int unsigned DADDR_W = 8
) (
    input  logic               Clk,
    input  logic               ResetN,
    instr_controller_if.master bus
`ifdef CTRL_STATE_OUT_EN
    ,
    output logic [STATE_W-1:0] CurState
`endif
);

    state_e               state_q;
    state_e               state_d;
    logic [PC_W-1:0]      pc;
    logic [INSTR_W-1:0]   ir;
    logic                 ir_load_c;
    logic [OP_W-1:0]      opcode_c;
    logic [DADDR_W-1:0]   d_addr_c;

    assign ir_load_c = (state_q == S_WAIT);
    assign opcode_c  = ir[15:12];
    assign d_addr_c  = DADDR_W'(ir[11:4]);

    pc_ir_reg #(
        .PC_W (PC_W),
        .IR_W (INSTR_W)
    ) u_pc_ir (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .load       (ir_load_c),
        .instr_data (bus.InstrData),
        .pc         (pc),
        .ir         (ir)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_WAIT;
            S_WAIT:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_c)
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Moore output decode from registered state and IR.
    always_comb begin
        bus.InstrAddr  = pc;
        bus.D_Addr     = '0;
        bus.D_Wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_en    = 1'b0;
        bus.RF_W_addr  = '0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.ALU_s      = ALU_PASS;
        bus.Halted     = 1'b0;
        case (state_q)
            S_LOAD_A: bus.D_Addr = d_addr_c;
            S_LOAD_B: begin
                bus.D_Addr    = d_addr_c;
                bus.RF_s      = 1'b1;
                bus.RF_W_en   = 1'b1;
                bus.RF_W_addr = ir[3:0];
            end
            S_STORE: begin
                bus.D_Addr     = d_addr_c;
                bus.RF_Ra_addr = ir[3:0];
                bus.D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = ir[11:8];
                bus.RF_Rb_addr = ir[7:4];
                bus.ALU_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
                bus.RF_W_en    = 1'b1;
                bus.RF_W_addr  = ir[3:0];
            end
            S_HALT:  bus.Halted = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_STATE_OUT_EN
    assign CurState = state_q;
`endif

endmodule

// File: tb/tb_instr_controller.sv
// Directed bench for instr_controller with a synchronous ROM model.
// Optional CurState checks are compiled when CTRL_STATE_OUT_EN is defined.
module tb_instr_controller;
    import ctrl_pkg::*;

    logic        Clk;
    logic        ResetN;
    logic [15:0] rom [128];
    int          passed;
    int          total;
`ifdef CTRL_STATE_OUT_EN
    logic [3:0]  cur_state;
`endif

    instr_controller_if #(.PC_W(7), .DADDR_W(8)) bus ();

    instr_controller #(.PC_W(7), .DADDR_W(8)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
`ifdef CTRL_STATE_OUT_EN
        ,
        .CurState (cur_state)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous instruction ROM: data valid one cycle after address.
    always @(posedge Clk) bus.InstrData <= rom[bus.InstrAddr];

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp);
`ifdef CTRL_STATE_OUT_EN
        chk(tag, 32'(cur_state), 32'(exp));
`else
        if (exp === 4'hx) $display("unreachable %s", tag);
`endif
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_dwr"},  32'(bus.D_Wr),    32'd0);
        chk({tag, "_wen"},  32'(bus.RF_W_en), 32'd0);
        chk({tag, "_rfs"},  32'(bus.RF_s),    32'd0);
        chk({tag, "_alu"},  32'(bus.ALU_s),   32'd0);
        chk({tag, "_dadr"}, 32'(bus.D_Addr),  32'd0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        ResetN = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h21A5;
        rom[1] = 16'h3125;
        rom[2] = 16'h4125;
        rom[3] = 16'h13F7;
        rom[4] = 16'hF123;
        rom[5] = 16'h5000;

        tick(3);
        chk("rst_addr", 32'(bus.InstrAddr), 32'd0);
        chk("rst_halt", 32'(bus.Halted), 32'd0);
        chk_quiet("rst");
        ResetN = 1'b1;
        chk_st("init_st", 4'd0);
        tick(1);
        chk("fetch0_addr", 32'(bus.InstrAddr), 32'd0);
        chk_st("fetch0_st", 4'd1);
        tick(2);
        chk_quiet("decode0");
        tick(1);
        chk("loada_daddr", 32'(bus.D_Addr), 32'h1A);
        chk("loada_dwr", 32'(bus.D_Wr), 32'd0);
        chk("loada_wen", 32'(bus.RF_W_en), 32'd0);
        tick(1);
        chk("loadb_daddr", 32'(bus.D_Addr), 32'h1A);
        chk("loadb_rfs", 32'(bus.RF_s), 32'd1);
        chk("loadb_wen", 32'(bus.RF_W_en), 32'd1);
        chk("loadb_waddr", 32'(bus.RF_W_addr), 32'd5);
        tick(1);
        chk("fetch1_addr", 32'(bus.InstrAddr), 32'd1);
        chk("fetch1_wen", 32'(bus.RF_W_en), 32'd0);

        tick(3);
        chk("add_ra", 32'(bus.RF_Ra_addr), 32'd1);
        chk("add_rb", 32'(bus.RF_Rb_addr), 32'd2);
        chk("add_wa", 32'(bus.RF_W_addr), 32'd5);
        chk("add_alu", 32'(bus.ALU_s), 32'd1);
        chk("add_wen", 32'(bus.RF_W_en), 32'd1);
        chk("add_rfs", 32'(bus.RF_s), 32'd0);
        tick(1);
        chk("fetch2_addr", 32'(bus.InstrAddr), 32'd2);
        chk("fetch2_wen", 32'(bus.RF_W_en), 32'd0);

        tick(3);
        chk("sub_ra", 32'(bus.RF_Ra_addr), 32'd1);
        chk("sub_rb", 32'(bus.RF_Rb_addr), 32'd2);
        chk("sub_wa", 32'(bus.RF_W_addr), 32'd5);
        chk("sub_alu", 32'(bus.ALU_s), 32'd2);
        chk("sub_wen", 32'(bus.RF_W_en), 32'd1);
        tick(1);
        chk("fetch3_addr", 32'(bus.InstrAddr), 32'd3);

        tick(3);
        chk("store_daddr", 32'(bus.D_Addr), 32'h3F);
        chk("store_ra", 32'(bus.RF_Ra_addr), 32'd7);
        chk("store_dwr", 32'(bus.D_Wr), 32'd1);
        chk("store_wen", 32'(bus.RF_W_en), 32'd0);
        chk_st("store_st", 4'd7);
        tick(1);
        chk("fetch4_addr", 32'(bus.InstrAddr), 32'd4);
        chk("fetch4_dwr", 32'(bus.D_Wr), 32'd0);

        tick(3);
        chk_quiet("unk");
        chk_st("unk_st", 4'd4);
        tick(1);
        chk("fetch5_addr", 32'(bus.InstrAddr), 32'd5);

        tick(3);
        chk("halt_on", 32'(bus.Halted), 32'd1);
        for (int i = 0; i < 22; i++) begin
            tick(1);
            chk("halt_hold", 32'(bus.Halted), 32'd1);
            chk("halt_addr", 32'(bus.InstrAddr), 32'd6);
            chk("halt_wen", 32'(bus.RF_W_en), 32'd0);
            chk("halt_dwr", 32'(bus.D_Wr), 32'd0);
        end
        chk_st("halt_st", 4'd10);

        ResetN = 1'b0;
        #1;
        chk("hrst_halt", 32'(bus.Halted), 32'd0);
        chk("hrst_addr", 32'(bus.InstrAddr), 32'd0);
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        tick(1);
        ResetN = 1'b1;
        chk_st("hrst_st", 4'd0);
        tick(1);
        for (int i = 0; i < 128; i++) begin
            chk("wrap_addr", 32'(bus.InstrAddr), 32'(i));
            chk("wrap_wen", 32'(bus.RF_W_en), 32'd0);
            tick(4);
        end
        chk("wrap_final", 32'(bus.InstrAddr), 32'd0);

        ResetN = 1'b0;
        rom[0] = 16'h3125;
        tick(2);
        ResetN = 1'b1;
        tick(4);
        chk("abort_pre_wen", 32'(bus.RF_W_en), 32'd1);
        ResetN = 1'b0;
        #1;
        chk("abort_wen", 32'(bus.RF_W_en), 32'd0);
        chk("abort_addr", 32'(bus.InstrAddr), 32'd0);
        tick(1);
        ResetN = 1'b1;
        tick(1);
        chk("abort_fetch_addr", 32'(bus.InstrAddr), 32'd0);
        chk("abort_fetch_wen", 32'(bus.RF_W_en), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_controller.md
Name: instr_controller

Overview:
- Multi-cycle control unit for the 16x16 register-file datapath.
- Owns the program counter (PC) and instruction register (IR) and fetches from a synchronous instruction ROM.
- Decodes opcodes and drives register-file read/write addresses, the write enable, the data-memory address and write strobe, the ALU select, and the write-back mux select.
- Sits directly upstream of the register file. Every register-file control input comes from this block.

Parameters:
- PC_W, 7, PC and instruction-ROM address width (128 words).
- DADDR_W, 8, data-memory address width.

Ports:
- Clk  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- InstrData  in  16  instruction ROM read data; valid one cycle after InstrAddr is presented.
- InstrAddr  out  PC_W  instruction ROM address (equals PC).
- D_Addr  out  DADDR_W  data-memory address.
- D_Wr  out  1  data-memory write strobe.
- RF_s  out  1  write-back select: 1 = data memory, 0 = ALU.
- RF_W_en  out  1  register-file write enable.
- RF_W_addr  out  4  register-file write address.
- RF_Ra_addr  out  4  register-file A-side read address.
- RF_Rb_addr  out  4  register-file B-side read address.
- ALU_s  out  3  ALU operation: 0 pass A, 1 add, 2 sub.
- Halted  out  1  high while in HALT.

Behaviour:
- Reset: ResetN low asynchronously forces state INIT, PC=0, IR=0. All outputs are 0. Halted=0.
- Instruction format: IR[15:12] is the opcode.
  - 0001 STORE: D_Addr=IR[11:4], source Ra=IR[3:0].
  - 0010 LOAD: D_Addr=IR[11:4], dest Rd=IR[3:0].
  - 0011 ADD, 0100 SUB: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0].
  - 0101 HALT.
  - 0000 and all other opcodes are NOOP.
- States and transitions:
  - INIT -> FETCH.
  - FETCH: InstrAddr=PC. -> WAIT.
  - WAIT: at the clock edge, IR<=InstrData and PC<=PC+1 (PC wraps 127 -> 0). -> DECODE.
  - DECODE: no output strobes. Branches on IR opcode to NOOP, LOAD_A, STORE, ADD, SUB or HALT.
  - NOOP -> FETCH.
  - LOAD_A: D_Addr=IR[11:4], D_Wr=0 (data memory has 1-cycle read latency). -> LOAD_B.
  - LOAD_B: D_Addr held, RF_s=1, RF_W_en=1, RF_W_addr=IR[3:0]. -> FETCH.
  - STORE: D_Addr=IR[11:4], RF_Ra_addr=IR[3:0], D_Wr=1. -> FETCH.
  - ADD / SUB: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], ALU_s=1 or 2, RF_s=0, RF_W_en=1, RF_W_addr=IR[3:0]. -> FETCH.
  - HALT: Halted=1. Stays in HALT until reset.
- Moore outputs, decoded combinationally from the registered state and IR. RF_W_en and D_Wr are high only in the states listed above; every output not listed for a state is 0.
- Latency per instruction, FETCH to FETCH: NOOP 4, ADD/SUB/STORE 4, LOAD 5 cycles.
- Register write occurs at the clock edge ending LOAD_B or ADD/SUB. The written value is readable in the following cycle.
- Reset asserted mid-instruction aborts it immediately. A write strobe in progress never completes a partial instruction after release.
- PC increments exactly once per fetched instruction. HALT never increments the PC further.

Optional Feature:
- Macro CTRL_STATE_OUT_EN.
- When defined: adds output port CurState (4 bits) carrying the state encoding, for seven-segment debug display:
  - INIT=0, FETCH=1, WAIT=2, DECODE=3, NOOP=4, LOAD_A=5, LOAD_B=6, STORE=7, ADD=8, SUB=9, HALT=10.
- When undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package ctrl_pkg:
  - state enum (encodings above);
  - opcode constants OP_NOOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_HALT;
  - ALU_s constants ALU_PASS, ALU_ADD, ALU_SUB.
- One natural sub-module, pc_ir_reg: PC counter with wrap and IR load, controlled by a load strobe from the FSM. The FSM and output decode stay in instr_controller.

Test Plan:
- Reset: hold ResetN=0 for 3 cycles, release -> InstrAddr=0, all strobes 0; FETCH with InstrAddr=0 appears 1 cycle after release.
- LOAD, InstrData=16'h2_1A5 -> LOAD_A drives D_Addr=8'h1A; LOAD_B drives RF_s=1, RF_W_en=1, RF_W_addr=5; next FETCH InstrAddr=1.
- ADD, InstrData=16'h3_125 -> RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=5, ALU_s=1, RF_W_en=1 for exactly 1 cycle. SUB 16'h4_125 gives the same fields with ALU_s=2.
- STORE, InstrData=16'h1_3F7 -> D_Addr=8'h3F, RF_Ra_addr=7, D_Wr=1 for 1 cycle, RF_W_en=0.
- HALT, InstrData=16'h5000 -> Halted=1 for 20+ cycles, InstrAddr frozen, no strobes. Pulse ResetN low -> INIT, PC=0.
- PC wrap: execute 128 NOOPs (16'h0000) -> InstrAddr sequence 0..127 then 0. Unknown opcode 16'hF123 behaves as NOOP with no strobes.
